// File: rtl/if_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package if_stage_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] HALT_INSTR       = 32'hFFFF_FFFF;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_RUN  = 2'd1,
    IF_HALT = 2'd2
  } if_state_e;

  typedef struct packed {
    logic [31:0] next_pc;
    logic [31:0] instr;
    logic        valid;
  } ifid_t;

  localparam ifid_t IFID_NOP = '{next_pc: '0, instr: NOP_INSTR, valid: 1'b0};

endpackage

// File: rtl/if_stage_instruction_memory.sv
// Word-addressed instruction store: combinational read, gated synchronous write,
// NOP for any byte address past the end of the array.
module instruction_memory
  import if_stage_pkg::*;
#(
  parameter int unsigned DEPTH = 256
) (
  input  logic        clk,
  input  logic        we_i,
  input  logic [31:0] waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] raddr_i,
  output logic [31:0] rdata_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] widx;
  logic [AW-1:0] ridx;
  logic          w_in_range;
  logic          r_in_range;
  logic          unused_byte_bits;

  assign widx       = waddr_i[AW+1:2];
  assign ridx       = raddr_i[AW+1:2];
  assign w_in_range = (waddr_i[31:AW+2] == '0);
  assign r_in_range = (raddr_i[31:AW+2] == '0);
  assign unused_byte_bits = ^{waddr_i[1:0], raddr_i[1:0]};

  always_ff @(posedge clk) begin
    if (we_i && w_in_range) begin
      mem_q[widx] <= wdata_i;
    end
  end

  always_comb begin
    rdata_o = NOP_INSTR;
    if (r_in_range) begin
      rdata_o = mem_q[ridx];
    end
  end

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC register, run/halt FSM, IF/ID register and
// the loadable instruction memory.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_branch_prediction,
  input  logic [31:0] i_branch_target_addr,
  input  logic        i_mispredict,
  input  logic [31:0] i_correct_pc,
  input  logic        i_imem_write_en,
  input  logic [31:0] i_imem_write_addr,
  input  logic [31:0] i_imem_write_data,
  output logic [31:0] o_next_pc,
  output logic [31:0] o_instruction,
  output logic        o_valid,
  output logic [31:0] o_pc,
  output logic        o_halt
);

  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  ifid_t       ifid_q, ifid_d;
  logic [31:0] fetch_word;
  logic [31:0] pc_plus4;

  instruction_memory #(
    .DEPTH(IMEM_DEPTH)
  ) u_imem (
    .clk     (clk),
    .we_i    (i_imem_write_en && (state_q == IF_IDLE)),
    .waddr_i (i_imem_write_addr),
    .wdata_i (i_imem_write_data),
    .raddr_i (pc_q),
    .rdata_o (fetch_word)
  );

  assign pc_plus4 = pc_q + 32'd4;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IF_IDLE;
      pc_q    <= RESET_PC;
      ifid_q  <= IFID_NOP;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ifid_d  = ifid_q;
    unique case (state_q)
      IF_IDLE: begin
        pc_d   = RESET_PC;
        ifid_d = IFID_NOP;
        if (i_start) begin
          state_d = IF_RUN;
        end
      end
      IF_RUN: begin
        if (i_mispredict) begin
          pc_d   = i_correct_pc;
          ifid_d = IFID_NOP;
        end else if (i_stall) begin
          pc_d   = pc_q;
        end else if (i_flush) begin
          pc_d   = pc_plus4;
          ifid_d = IFID_NOP;
        end else if (i_branch_prediction) begin
          pc_d   = i_branch_target_addr;
          ifid_d = IFID_NOP;
        end else if (fetch_word == HALT_INSTR) begin
          // HALT only commits on an unredirected fetch; PC stays on it.
          ifid_d  = IFID_NOP;
          state_d = IF_HALT;
        end else begin
          pc_d   = pc_plus4;
          ifid_d = '{next_pc: pc_plus4, instr: fetch_word, valid: 1'b1};
        end
      end
      IF_HALT: begin
        ifid_d = IFID_NOP;
        if (i_mispredict) begin
          pc_d    = i_correct_pc;
          state_d = IF_RUN;
        end
      end
      default: begin
        state_d = IF_IDLE;
        pc_d    = RESET_PC;
        ifid_d  = IFID_NOP;
      end
    endcase
  end

  assign o_next_pc     = ifid_q.next_pc;
  assign o_instruction = ifid_q.instr;
  assign o_valid       = ifid_q.valid;
  assign o_pc          = pc_q;
  assign o_halt        = (state_q == IF_HALT);

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: a behavioural fetch model predicts each cycle's
// outputs, queues them at drive time and compares them after the clock edge.
module tb_if_stage;

  typedef struct {
    logic        start, stall, flush, bp, misp, we;
    logic [31:0] tgt, cpc, waddr, wdata;
  } stim_t;

  typedef struct {
    logic [31:0] pc, instr, npc;
    logic        valid, halt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_start, i_stall, i_flush, i_branch_prediction, i_mispredict;
  logic        i_imem_write_en;
  logic [31:0] i_branch_target_addr, i_correct_pc, i_imem_write_addr, i_imem_write_data;
  logic [31:0] o_next_pc, o_instruction, o_pc;
  logic        o_valid, o_halt;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  exp_t        sbq[$];

  // reference model state (0 idle, 1 run, 2 halt)
  int          m_st;
  logic [31:0] m_pc, m_npc, m_ins;
  logic        m_val;
  logic [31:0] m_mem [256];

  if_stage #(
    .IMEM_DEPTH(256),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .i_start             (i_start),
    .i_stall             (i_stall),
    .i_flush             (i_flush),
    .i_branch_prediction (i_branch_prediction),
    .i_branch_target_addr(i_branch_target_addr),
    .i_mispredict        (i_mispredict),
    .i_correct_pc        (i_correct_pc),
    .i_imem_write_en     (i_imem_write_en),
    .i_imem_write_addr   (i_imem_write_addr),
    .i_imem_write_data   (i_imem_write_data),
    .o_next_pc           (o_next_pc),
    .o_instruction       (o_instruction),
    .o_valid             (o_valid),
    .o_pc                (o_pc),
    .o_halt              (o_halt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_fetch(input logic [31:0] pc);
    if (pc < 32'd1024) return m_mem[pc[9:2]];
    return 32'h0;
  endfunction

  task automatic model_reset();
    m_st = 0; m_pc = 32'h0; m_npc = 32'h0; m_ins = 32'h0; m_val = 1'b0;
  endtask

  task automatic m_nop();
    m_npc = 32'h0; m_ins = 32'h0; m_val = 1'b0;
  endtask

  task automatic model_step(input stim_t s);
    logic [31:0] f;
    f = m_fetch(m_pc);
    if (m_st == 0) begin
      if (s.we && s.waddr < 32'd1024) m_mem[s.waddr[9:2]] = s.wdata;
      m_pc = 32'h0;
      m_nop();
      if (s.start) m_st = 1;
    end else if (m_st == 1) begin
      if (s.misp) begin
        m_pc = s.cpc; m_nop();
      end else if (s.stall) begin
        // hold everything
      end else if (s.flush) begin
        m_pc = m_pc + 32'd4; m_nop();
      end else if (s.bp) begin
        m_pc = s.tgt; m_nop();
      end else if (f == 32'hFFFF_FFFF) begin
        m_nop(); m_st = 2;
      end else begin
        m_npc = m_pc + 32'd4; m_ins = f; m_val = 1'b1; m_pc = m_pc + 32'd4;
      end
    end else begin
      m_nop();
      if (s.misp) begin
        m_pc = s.cpc; m_st = 1;
      end
    end
  endtask

  task automatic step(input stim_t s);
    exp_t e, got;
    i_start = s.start; i_stall = s.stall; i_flush = s.flush;
    i_branch_prediction = s.bp; i_branch_target_addr = s.tgt;
    i_mispredict = s.misp; i_correct_pc = s.cpc;
    i_imem_write_en = s.we; i_imem_write_addr = s.waddr; i_imem_write_data = s.wdata;
    model_step(s);
    e = '{pc: m_pc, instr: m_ins, npc: m_npc, valid: m_val, halt: (m_st == 2)};
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      check_eq("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      got = sbq.pop_front();
      check_eq("o_pc", o_pc, got.pc);
      check_eq("o_instruction", o_instruction, got.instr);
      check_eq("o_next_pc", o_next_pc, got.npc);
      check_eq("o_valid", {31'd0, o_valid}, {31'd0, got.valid});
      check_eq("o_halt", {31'd0, o_halt}, {31'd0, got.halt});
    end
    @(negedge clk);
  endtask

  function automatic stim_t idle_s();
    stim_t s;
    s.start = 0; s.stall = 0; s.flush = 0; s.bp = 0; s.misp = 0; s.we = 0;
    s.tgt = '0; s.cpc = '0; s.waddr = '0; s.wdata = '0;
    return s;
  endfunction

  initial begin
    stim_t s;
    logic [31:0] w;
    reset = 1'b0;
    s = idle_s();
    i_start = 0; i_stall = 0; i_flush = 0; i_branch_prediction = 0; i_mispredict = 0;
    i_imem_write_en = 0; i_branch_target_addr = '0; i_correct_pc = '0;
    i_imem_write_addr = '0; i_imem_write_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("rst_pc", o_pc, 32'h0);
    check_eq("rst_instr", o_instruction, 32'h0);
    check_eq("rst_npc", o_next_pc, 32'h0);
    check_eq("rst_valid", {31'd0, o_valid}, 32'd0);
    check_eq("rst_halt", {31'd0, o_halt}, 32'd0);
    reset = 1'b1;

    // program load: HALT at word 2, distinct filler elsewhere
    for (int unsigned i = 0; i < 32; i++) begin
      w = (i == 0) ? 32'h2008_0005 : (i == 1) ? 32'h2009_0003 :
          (i == 2) ? 32'hFFFF_FFFF : (32'h3C00_0000 | i);
      s = idle_s(); s.we = 1; s.waddr = i * 4; s.wdata = w;
      step(s);
    end
    s = idle_s(); step(s);
    s = idle_s(); s.start = 1; step(s);
    s = idle_s(); step(s);
    check_eq("tp_first_instr", o_instruction, 32'h2008_0005);
    step(s);
    check_eq("tp_second_npc", o_next_pc, 32'h0000_0008);
    step(s);
    check_eq("tp_halt_pc", o_pc, 32'h0000_0008);
    s = idle_s(); s.start = 1; step(s);
    s = idle_s(); s.we = 1; s.waddr = 32'h0; s.wdata = 32'hDEAD_BEEF; step(s);

    s = idle_s(); s.misp = 1; s.cpc = 32'h20; step(s);
    check_eq("tp_resume_pc", o_pc, 32'h20);
    s = idle_s(); step(s);
    s = idle_s(); s.misp = 1; s.cpc = 32'h10; step(s);
    s = idle_s(); s.bp = 1; s.tgt = 32'h40; step(s);
    s = idle_s(); step(s);
    check_eq("tp_branch_npc", o_next_pc, 32'h44);
    s = idle_s(); s.stall = 1; s.bp = 1; s.tgt = 32'h60; step(s); step(s);
    s = idle_s(); s.stall = 1; s.misp = 1; s.cpc = 32'h30; step(s);
    s = idle_s(); step(s);
    s = idle_s(); s.flush = 1; step(s);
    s = idle_s(); step(s);
    s = idle_s(); s.flush = 1; s.bp = 1; s.tgt = 32'h70; step(s);
    s = idle_s(); s.misp = 1; s.cpc = 32'hFFFF_FFFC; step(s);
    s = idle_s(); step(s);
    check_eq("tp_wrap_pc", o_pc, 32'h0);
    step(s);
    s = idle_s(); s.we = 1; s.waddr = 32'h0; s.wdata = 32'h1234_5678; step(s);
    s = idle_s(); s.misp = 1; s.cpc = 32'h18; step(s);
    s = idle_s(); step(s);
    check_eq("tp_pc_1c", o_pc, 32'h1C);

    // asynchronous reset between edges
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_eq("arst_pc", o_pc, 32'h0);
    check_eq("arst_valid", {31'd0, o_valid}, 32'd0);
    check_eq("arst_instr", o_instruction, 32'h0);
    check_eq("arst_halt", {31'd0, o_halt}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    s = idle_s(); s.start = 1; step(s);
    s = idle_s(); step(s);
    check_eq("tp_mem_unchanged", o_instruction, 32'h2008_0005);

    for (int unsigned k = 0; k < 80; k++) begin
      s = idle_s();
      s.stall = ($urandom_range(0, 5) == 0);
      s.flush = ($urandom_range(0, 7) == 0);
      s.bp    = ($urandom_range(0, 5) == 0);
      s.tgt   = $urandom_range(0, 31) * 4;
      s.misp  = ($urandom_range(0, 7) == 0);
      s.cpc   = $urandom_range(0, 31) * 4;
      s.start = ($urandom_range(0, 3) == 0);
      s.we    = ($urandom_range(0, 3) == 0);
      s.waddr = $urandom_range(0, 31) * 4;
      s.wdata = $urandom;
      step(s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
